// File: rtl/dmem_bus_bridge.sv
// rtl/dmem_bus_bridge.sv - core data-memory port to single-beat req/ack bus bridge
// Stalls the core while a bus access is outstanding and reports misaligned, bus-error and timeout faults.
module dmem_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  input  logic [2:0]  core_width_i,
  output logic [31:0] core_rdata_o,
  output logic        core_stall_o,
  output logic        fault_valid_o,
  output logic [1:0]  fault_cause_o,
  output logic [31:0] fault_addr_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int unsigned CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TLIM = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TLIM);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    off;
  logic [31:0]   acc_addr;
  logic          legal;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic          timed_out;

  always_comb begin
    legal   = 1'b0;
    be_c    = 4'b0000;
    wdata_c = core_wdata_i;
    case (core_width_i)
      3'b000, 3'b100: begin
        legal   = 1'b1;
        be_c    = 4'b0001 << core_addr_i[1:0];
        wdata_c = {4{core_wdata_i[7:0]}};
      end
      3'b001, 3'b101: begin
        legal   = ~core_addr_i[0];
        be_c    = 4'b0011 << {core_addr_i[1], 1'b0};
        wdata_c = {2{core_wdata_i[15:0]}};
      end
      3'b010: begin
        legal   = (core_addr_i[1:0] == 2'b00);
        be_c    = 4'b1111;
      end
      default: ;
    endcase
  end

  // The counter starts at zero on BUSY entry, so the last permitted BUSY cycle sees TIMEOUT_CYCLES-1.
  assign timed_out    = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
  assign core_stall_o = ((state == IDLE) && core_req_i && legal) || (state == BUSY);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      off           <= 2'b00;
      acc_addr      <= 32'h0;
      bus_req_o     <= 1'b0;
      bus_we_o      <= 1'b0;
      bus_addr_o    <= 32'h0;
      bus_wdata_o   <= 32'h0;
      bus_be_o      <= 4'b0000;
      core_rdata_o  <= 32'h0;
      fault_valid_o <= 1'b0;
      fault_cause_o <= 2'b00;
      fault_addr_o  <= 32'h0;
    end else begin
      fault_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (core_req_i && legal) begin
            state       <= BUSY;
            cnt         <= '0;
            off         <= core_addr_i[1:0];
            acc_addr    <= core_addr_i;
            bus_req_o   <= 1'b1;
            bus_we_o    <= core_we_i;
            bus_addr_o  <= {core_addr_i[31:2], 2'b00};
            bus_wdata_o <= wdata_c;
            bus_be_o    <= be_c;
          end else if (core_req_i) begin
            fault_valid_o <= 1'b1;
            fault_cause_o <= 2'b01;
            fault_addr_o  <= core_addr_i;
          end
        end
        BUSY: begin
          if (bus_err_i) begin
            state         <= DONE;
            bus_req_o     <= 1'b0;
            core_rdata_o  <= 32'h0;
            fault_valid_o <= 1'b1;
            fault_cause_o <= 2'b10;
            fault_addr_o  <= acc_addr;
          end else if (bus_ack_i) begin
            state        <= DONE;
            bus_req_o    <= 1'b0;
            core_rdata_o <= bus_rdata_i >> {off, 3'b000};
          end else if (timed_out) begin
            state         <= DONE;
            bus_req_o     <= 1'b0;
            core_rdata_o  <= 32'h0;
            fault_valid_o <= 1'b1;
            fault_cause_o <= 2'b11;
            fault_addr_o  <= acc_addr;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb/tb_dmem_bus_bridge.sv - table-driven and randomized bench for dmem_bus_bridge
module tb_dmem_bus_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [2:0]  core_width;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        fault_valid;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_width_i(core_width), .core_rdata_o(core_rdata),
    .core_stall_o(core_stall), .fault_valid_o(fault_valid), .fault_cause_o(fault_cause),
    .fault_addr_o(fault_addr), .bus_req_o(bus_req), .bus_we_o(bus_we),
    .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_be_o(bus_be),
    .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata), .bus_err_i(bus_err)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  width;
    int          k;
    int          mode;
    logic [31:0] brd;
    logic        legal;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] erd;
    logic [1:0]  cause;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // mode: 0 ack, 1 err, 2 ack+err, 3 silent; k is the BUSY cycle (1-based) carrying the response
  task automatic run_access(input string n, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [2:0] w, input int k,
                            input int mode, input logic [31:0] brd, input logic legal,
                            input logic [3:0] ebe, input logic [31:0] ewd,
                            input logic [31:0] erd, input logic [1:0] ecause);
    logic fin;
    core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wd; core_width = w;
    #1;
    chk({n, "_stall_req"}, 32'(core_stall), 32'(legal));
    step();
    if (!legal) begin
      chk({n, "_fv"}, 32'(fault_valid), 32'd1);
      chk({n, "_cause"}, 32'(fault_cause), 32'd1);
      chk({n, "_faddr"}, fault_addr, addr);
      chk({n, "_noreq"}, 32'(bus_req), 32'd0);
      chk({n, "_nostall"}, 32'(core_stall), 32'd0);
      core_req = 1'b0;
      step();
      chk({n, "_fv_pulse"}, 32'(fault_valid), 32'd0);
      return;
    end
    for (int c = 1; c <= 64; c++) begin
      chk({n, "_busreq"}, 32'(bus_req), 32'd1);
      chk({n, "_stall_busy"}, 32'(core_stall), 32'd1);
      if (c == 1) begin
        chk({n, "_baddr"}, bus_addr, {addr[31:2], 2'b00});
        chk({n, "_be"}, 32'(bus_be), 32'(ebe));
        chk({n, "_we"}, 32'(bus_we), 32'(we));
        if (we) chk({n, "_wdata"}, bus_wdata, ewd);
      end
      fin = 1'b0;
      if (mode != 3 && c == k) begin
        bus_ack = (mode != 1); bus_err = (mode != 0); bus_rdata = brd; fin = 1'b1;
      end
      if (c == TO) fin = 1'b1;
      step();
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
      if (fin) break;
    end
    chk({n, "_done_req"}, 32'(bus_req), 32'd0);
    chk({n, "_done_stall"}, 32'(core_stall), 32'd0);
    chk({n, "_done_fv"}, 32'(fault_valid), 32'(ecause != 2'b00));
    chk({n, "_rdata"}, core_rdata, erd);
    if (ecause != 2'b00) begin
      chk({n, "_done_cause"}, 32'(fault_cause), 32'(ecause));
      chk({n, "_done_faddr"}, fault_addr, addr);
    end
    core_req = 1'b0;
    step();
    chk({n, "_idle_fv"}, 32'(fault_valid), 32'd0);
    chk({n, "_idle_req"}, 32'(bus_req), 32'd0);
  endtask

  function automatic int size_of(input logic [2:0] w);
    if (w == 3'b000 || w == 3'b100) return 1;
    if (w == 3'b001 || w == 3'b101) return 2;
    if (w == 3'b010) return 4;
    return 0;
  endfunction

  initial begin
    int sz, off, k, mode;
    logic [31:0] a, wd, brd, ewd, erd;
    logic [3:0] be;
    logic [2:0] w;
    logic lg, we;
    logic [1:0] cause;

    vecs[0] = '{"lw_100",   0, 32'h100, 32'h12345678, 3'b010, 2, 0, 32'hCAFEF00D, 1, 4'hF, 32'h12345678, 32'hCAFEF00D, 2'b00};
    vecs[1] = '{"sb_103",   1, 32'h103, 32'h000000A5, 3'b000, 1, 0, 32'h11223344, 1, 4'h8, 32'hA5A5A5A5, 32'h00000011, 2'b00};
    vecs[2] = '{"lh_102",   0, 32'h102, 32'h00005678, 3'b001, 3, 0, 32'hBEEF1234, 1, 4'hC, 32'h56785678, 32'h0000BEEF, 2'b00};
    vecs[3] = '{"lw_101",   0, 32'h101, 32'h0,        3'b010, 1, 0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        2'b01};
    vecs[4] = '{"lw_tmo",   0, 32'h200, 32'h0,        3'b010, 0, 3, 32'h0,        1, 4'hF, 32'h0,        32'h0,        2'b11};
    vecs[5] = '{"lb_both",  0, 32'h201, 32'h0,        3'b000, 2, 2, 32'h55555555, 1, 4'h2, 32'h0,        32'h0,        2'b10};
    vecs[6] = '{"w011",     0, 32'h300, 32'h0,        3'b011, 1, 0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        2'b01};
    vecs[7] = '{"lhu_101",  0, 32'h101, 32'h0,        3'b101, 1, 0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        2'b01};
    vecs[8] = '{"lbu_302",  0, 32'h302, 32'h0,        3'b100, 4, 0, 32'hAABBCCDD, 1, 4'h4, 32'h0,        32'h0000AABB, 2'b00};
    vecs[9] = '{"sw_err",   1, 32'h104, 32'hDEADBEEF, 3'b010, 1, 1, 32'h0,        1, 4'hF, 32'hDEADBEEF, 32'h0,        2'b10};

    rst_n = 1'b0; core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
    core_width = 3'b000; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    step();
    step();
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_rdata", core_rdata, 32'h0);
    chk("rst_fv", 32'(fault_valid), 32'd0);
    chk("rst_cause", 32'(fault_cause), 32'd0);
    chk("rst_faddr", fault_addr, 32'h0);
    chk("rst_stall", 32'(core_stall), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++)
      run_access(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].width, vecs[i].k,
                 vecs[i].mode, vecs[i].brd, vecs[i].legal, vecs[i].be, vecs[i].ewd,
                 vecs[i].erd, vecs[i].cause);

    // Reset while BUSY: request drops at once and a late ack is ignored.
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h400; core_width = 3'b010;
    step();
    chk("rstbusy_req_before", 32'(bus_req), 32'd1);
    rst_n = 1'b0; core_req = 1'b0;
    step();
    chk("rstbusy_req_after", 32'(bus_req), 32'd0);
    chk("rstbusy_stall", 32'(core_stall), 32'd0);
    rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    step();
    bus_ack = 1'b0;
    chk("late_ack_fv", 32'(fault_valid), 32'd0);
    chk("late_ack_rdata", core_rdata, 32'h0);
    chk("late_ack_req", 32'(bus_req), 32'd0);
    step();

    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1)); a = $urandom; wd = $urandom; brd = $urandom;
      w = 3'($urandom_range(0, 7)); k = $urandom_range(1, 6); mode = $urandom_range(0, 3);
      sz = size_of(w);
      off = int'(a % 4);
      lg = (sz != 0) && ((a % sz) == 0);
      be = 4'(((1 << sz) - 1) << off);
      for (int l = 0; l < 4; l++) ewd[8*l +: 8] = wd[8*((sz == 0) ? l : (l % sz)) +: 8];
      if (!lg) cause = 2'b01;
      else if (mode == 3 || k > TO) cause = 2'b11;
      else if (mode != 0) cause = 2'b10;
      else cause = 2'b00;
      erd = (cause == 2'b00) ? (brd / (32'd1 << (8 * off))) : 32'h0;
      run_access($sformatf("rnd%0d", i), we, a, wd, w, k, mode, brd, lg, be, ewd, erd, cause);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
